dm_port_arbiter: RTL and testbench

//  Shares the single data memory (DM, 128 B, big-endian, read registered on clk) between two

---
 rtl/dm_arb_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 27 ++
 rtl/dm_port_arbiter.sv | 132 +++++++++++++
 tb/tb_dm_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dm_arb_pkg
// Brief    : Shared types and constants for the data-memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic       P_CPU      = 1'b0;
    localparam logic       P_DMA      = 1'b1;
    localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-way round-robin grant selection; ties go to the port not last served.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
    import dm_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = |req;
        grant = P_CPU;
        if (&req) begin
            grant = ~last;
        end else if (req[P_DMA]) begin
            grant = P_DMA;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dm_port_arbiter
// Brief    : Shares the data memory between the CPU and DMA ports, one access at a time.
// Revision : 1.0 - initial release
// ============================================================================
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int   DATA_W    = 32,
    parameter int   ADDR_W    = 32,
    parameter int   MEM_BYTES = 128,
    parameter logic RST_LAST  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    output logic              dm_read,
    output logic              dm_write,
    input  logic [DATA_W-1:0] dm_rdata
);

    localparam logic [ADDR_W-1:0] C_LAST_WORD = ADDR_W'(MEM_BYTES - 4);

    state_t r_state;
    logic   r_last;
    logic   r_port;
    logic   r_we;
    logic   r_err;

    logic              w_grant;
    logic              w_valid;
    logic              w_gWe;
    logic [ADDR_W-1:0] w_gAddr;
    logic [DATA_W-1:0] w_gWdata;
    logic              w_bad;

    rr_arb2 u_rrArb (
        .req   ({req1, req0}),
        .last  (r_last),
        .grant (w_grant),
        .valid (w_valid)
    );

    assign w_gWe    = w_grant ? we1    : we0;
    assign w_gAddr  = w_grant ? addr1  : addr0;
    assign w_gWdata = w_grant ? wdata1 : wdata0;
    // Unsigned compare over the full address width, so wrapped addresses are rejected.
    assign w_bad    = ((w_gAddr[1:0] & ALIGN_MASK) != 2'b00) || (w_gAddr > C_LAST_WORD);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_last   <= RST_LAST;
            r_port   <= P_CPU;
            r_we     <= 1'b0;
            r_err    <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            err0     <= 1'b0;
            err1     <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
            dm_addr  <= '0;
            dm_wdata <= '0;
            dm_read  <= 1'b0;
            dm_write <= 1'b0;
        end else begin
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            err0   <= 1'b0;
            err1   <= 1'b0;
            rdata0 <= '0;
            rdata1 <= '0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_port <= w_grant;
                        r_last <= w_grant;
                        r_we   <= w_gWe;
                        r_err  <= w_bad;
                        if (w_bad) begin
                            r_state <= RESP;
                        end else begin
                            // DM address/data registers double as the request latch.
                            r_state  <= ISSUE;
                            dm_addr  <= w_gAddr;
                            dm_wdata <= w_gWdata;
                            dm_read  <= ~w_gWe;
                            dm_write <= w_gWe;
                        end
                    end
                end
                ISSUE: begin
                    dm_read  <= 1'b0;
                    dm_write <= 1'b0;
                    r_state  <= RESP;
                end
                RESP: begin
                    r_state <= IDLE;
                    if (r_port == P_DMA) begin
                        ack1   <= 1'b1;
                        err1   <= r_err;
                        rdata1 <= (!r_we && !r_err) ? dm_rdata : '0;
                    end else begin
                        ack0   <= 1'b1;
                        err0   <= r_err;
                        rdata0 <= (!r_we && !r_err) ? dm_rdata : '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_port_arbiter
// Brief    : Self-checking bench for dm_port_arbiter with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_port_arbiter;

    localparam int MEM_BYTES = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, err0, err1, dm_read, dm_write;
    logic [31:0] rdata0, rdata1, dm_addr, dm_wdata;
    logic [31:0] dm_rdata;

    always #5 clk = ~clk;

    dm_port_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata0(rdata0), .rdata1(rdata1),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_read(dm_read), .dm_write(dm_write),
        .dm_rdata(dm_rdata)
    );

    // Big-endian data memory with registered read and no reset.
    logic [7:0] dmMem [MEM_BYTES] = '{default: 8'h00};
    always @(posedge clk) begin
        if (dm_write && dm_addr <= 32'(MEM_BYTES - 4))
            for (int b = 0; b < 4; b++) dmMem[int'(dm_addr[6:0]) + b] <= dm_wdata[31-8*b -: 8];
        if (dm_read && dm_addr <= 32'(MEM_BYTES - 4))
            dm_rdata <= {dmMem[int'(dm_addr[6:0])], dmMem[int'(dm_addr[6:0])+1],
                         dmMem[int'(dm_addr[6:0])+2], dmMem[int'(dm_addr[6:0])+3]};
    end

    int checks = 0, failures = 0, cyc = 0;

    // Transaction-level model state.
    logic [7:0]  mMem [MEM_BYTES] = '{default: 8'h00};
    int          freeAt = 0, ackAt = -1, strobeCyc = -1;
    bit          mLast = 1'b1, pend = 1'b0, pPort, pErr, sWe;
    logic [31:0] pRdata, sAddr, sWdata;
    bit          inFlight [2] = '{0, 0};
    bit          mAckNow [2] = '{0, 0};
    bit          dutAckNow [2] = '{0, 0};
    int          dutAckCyc [2] = '{0, 0};
    int          dutAckCnt [2] = '{0, 0};
    int          dutAckLog [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // One clock: model the edge from pre-edge inputs, then compare every output.
    task automatic step();
        bit r0, r1, w0, w1, rs, g, we, bad;
        logic [31:0] a0, a1, d0, d1, a, d;
        bit eAck0, eAck1, sNow;
        r0 = req0; r1 = req1; w0 = we0; w1 = we1; rs = rst;
        a0 = addr0; a1 = addr1; d0 = wdata0; d1 = wdata1;
        @(posedge clk);
        cyc++;
        if (rs) begin
            pend = 0; strobeCyc = -1; freeAt = cyc + 1; mLast = 1'b1;
            inFlight[0] = 0; inFlight[1] = 0;
        end else if (cyc >= freeAt && (r0 || r1)) begin
            g = (r0 && r1) ? !mLast : r1;
            mLast = g;
            we = g ? w1 : w0; a = g ? a1 : a0; d = g ? d1 : d0;
            bad = (a % 4 != 0) || (a > 32'(MEM_BYTES - 4));
            pend = 1; pPort = g; pErr = bad; inFlight[g] = 1;
            pRdata = '0;
            if (bad) begin
                ackAt = cyc + 1;
            end else begin
                ackAt = cyc + 2; strobeCyc = cyc; sWe = we; sAddr = a; sWdata = d;
                for (int b = 0; b < 4; b++) begin
                    if (we) mMem[int'(a) + b] = d[31-8*b -: 8];
                    else    pRdata[31-8*b -: 8] = mMem[int'(a) + b];
                end
            end
            freeAt = ackAt + 1;
        end
        #1;
        eAck0 = pend && ackAt == cyc && pPort == 1'b0;
        eAck1 = pend && ackAt == cyc && pPort == 1'b1;
        chk("ack0", 32'(ack0), 32'(eAck0));
        chk("ack1", 32'(ack1), 32'(eAck1));
        chk("err0", 32'(err0), 32'(eAck0 && pErr));
        chk("err1", 32'(err1), 32'(eAck1 && pErr));
        chk("rdata0", rdata0, eAck0 ? pRdata : 32'h0);
        chk("rdata1", rdata1, eAck1 ? pRdata : 32'h0);
        sNow = (strobeCyc == cyc);
        chk("dm_read", 32'(dm_read), 32'(sNow && !sWe));
        chk("dm_write", 32'(dm_write), 32'(sNow && sWe));
        if (sNow) begin
            chk("dm_addr", dm_addr, sAddr);
            if (sWe) chk("dm_wdata", dm_wdata, sWdata);
        end
        mAckNow[0] = eAck0; mAckNow[1] = eAck1;
        dutAckNow[0] = ack0; dutAckNow[1] = ack1;
        for (int p = 0; p < 2; p++) if (dutAckNow[p]) begin
            dutAckCnt[p]++; dutAckCyc[p] = cyc; dutAckLog.push_back(p);
        end
        if (eAck0 || eAck1) begin pend = 0; inFlight[pPort] = 0; end
    endtask

    task automatic setReq(input int p, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
        else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    endtask

    task automatic waitAck(input int p, input int maxc);
        bit got = 0;
        for (int i = 0; i < maxc && !got; i++) begin
            step();
            if (dutAckNow[p]) got = 1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL waitAck port=%0d got=no-ack expected=ack within %0d cycles", p, maxc);
        end
        if (p == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    task automatic doReset(input int n);
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        repeat (n) step();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] genAddr();
        case ($urandom_range(0, 9))
            0: return 32'($urandom_range(0, 127)) | 32'h1;
            1: return 32'h80;
            2: return 32'hFFFF_FFFC;
            3: return 32'h7C;
            4: return $urandom;
            default: return {25'd0, 5'($urandom_range(0, 31)), 2'b00};
        endcase
    endfunction

    task automatic arm(input int p);
        setReq(p, 1'b1, 1'($urandom_range(0, 1)), genAddr(), $urandom);
    endtask

    int e0;

    initial begin
        // Reset state
        doReset(3);
        chk("rst_dm_addr", dm_addr, 32'h0);
        chk("rst_dm_wdata", dm_wdata, 32'h0);

        // Write then read back through port 0
        setReq(0, 1, 1, 32'h10, 32'hDEAD_BEEF);
        waitAck(0, 10);
        setReq(0, 1, 0, 32'h10, 32'h0);
        e0 = cyc + 1;
        waitAck(0, 10);
        chk("t1_latency", 32'(dutAckCyc[0] - e0), 32'd2);
        chk("t1_rdata0", rdata0, 32'hDEAD_BEEF);
        chk("t1_err0", 32'(err0), 32'd0);
        chk("t1_byte16", 32'(dmMem[16]), 32'hDE);
        chk("t1_byte17", 32'(dmMem[17]), 32'hAD);
        chk("t1_byte18", 32'(dmMem[18]), 32'hBE);
        chk("t1_byte19", 32'(dmMem[19]), 32'hEF);

        // Both ports held continuously alternate grants
        doReset(1);
        dutAckLog.delete();
        setReq(0, 1, 0, 32'h10, 32'h0);
        setReq(1, 1, 0, 32'h14, 32'h0);
        for (int i = 0; i < 30 && dutAckLog.size() < 4; i++) step();
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) step();
        chk("t2_nacks", 32'(dutAckLog.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < dutAckLog.size(); i++)
            chk($sformatf("t2_order%0d", i), 32'(dutAckLog[i]), 32'(i % 2));

        // Misaligned read on port 1
        setReq(1, 1, 0, 32'h6, 32'h0);
        e0 = cyc + 1;
        waitAck(1, 10);
        chk("t3_latency", 32'(dutAckCyc[1] - e0), 32'd1);
        chk("t3_err1", 32'(err1), 32'd1);
        chk("t3_rdata1", rdata1, 32'h0);

        // Range boundaries on port 0
        setReq(0, 1, 0, 32'h7C, 32'h0);
        waitAck(0, 10);
        chk("t4_err_7C", 32'(err0), 32'd0);
        setReq(0, 1, 0, 32'h80, 32'h0);
        waitAck(0, 10);
        chk("t4_err_80", 32'(err0), 32'd1);
        setReq(0, 1, 0, 32'hFFFF_FFFC, 32'h0);
        waitAck(0, 10);
        chk("t4_err_FFFFFFFC", 32'(err0), 32'd1);

        // Reset during the ISSUE cycle of a port 1 write
        repeat (2) step();
        setReq(1, 1, 1, 32'h20, 32'h1234_5678);
        step();
        chk("t5_issue_write", 32'(dm_write), 32'd1);
        req1 = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_noack", 32'(ack1), 32'd0);
        chk("t5_strobe_off", 32'(dm_write), 32'd0);
        setReq(1, 1, 0, 32'h20, 32'h0);
        e0 = cyc + 1;
        waitAck(1, 10);
        chk("t5_latency", 32'(dutAckCyc[1] - e0), 32'd2);
        chk("t5_rdata1", rdata1, 32'h1234_5678);

        // req0 dropped mid-transaction while req1 waits
        doReset(1);
        dutAckCnt[0] = 0;
        setReq(0, 1, 0, 32'h10, 32'h0);
        setReq(1, 1, 0, 32'h14, 32'h0);
        step();
        step();
        req0 = 1'b0;
        waitAck(1, 12);
        repeat (3) step();
        chk("t6_ack0_count", 32'(dutAckCnt[0]), 32'd1);
        chk("t6_ack1_gap", 32'(dutAckCyc[1] - dutAckCyc[0]), 32'd3);

        // Randomized traffic
        doReset(1);
        for (int n = 0; n < 1500; n++) begin
            step();
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
            end
            for (int p = 0; p < 2; p++) begin
                if (mAckNow[p]) begin
                    if ($urandom_range(0, 1) == 1) arm(p);
                    else if (p == 0) req0 = 1'b0; else req1 = 1'b0;
                end else if (inFlight[p]) begin
                    if ($urandom_range(0, 3) == 0) setReq(p, (p == 0) ? req0 : req1, 1'($urandom_range(0, 1)), genAddr(), $urandom);
                    if ($urandom_range(0, 7) == 0) begin if (p == 0) req0 = 1'b0; else req1 = 1'b0; end
                end else if (!((p == 0) ? req0 : req1) && $urandom_range(0, 2) == 0) begin
                    arm(p);
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0; rst = 1'b0;
        repeat (5) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
